branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

In-order tracking queue for the update side of the branch predictor. Fetch pushes one entry per issued instruction with the prediction it used; execute resolves the oldest entry with the actual outcome. The block drives the predictor's check-side update (`pc_check`, `is_br_check`, `br_taken_check`) and raises a registered mispredict/redirect toward fetch, flushing all younger entries.

## Interface
- `PC_WIDTH`, 32, width of all PC/target fields
- `DEPTH`, 4, entry count; power of two, 2..16
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `push_valid`  in  1  fetch offers an entry
- `push_ready`  out  1  `!full`; entry accepted on edge when `push_valid && push_ready`
- `push_pc`  in  PC_WIDTH  PC of the fetched instruction
- `push_is_br`  in  1  instruction is a conditional branch
- `push_pred_taken`  in  1  prediction used by fetch
- `res_valid`  in  1  execute resolves the oldest entry this cycle
- `res_taken`  in  1  actual outcome (ignored for non-branch entries)
- `res_target`  in  PC_WIDTH  taken target
- `pc_check`  out  PC_WIDTH  registered PC of the resolved entry
- `is_br_check`  out  1  registered one-cycle pulse: resolved entry was a branch
- `br_taken_check`  out  1  registered actual outcome
- `mispredict`  out  1  registered one-cycle pulse
- `redirect_pc`  out  PC_WIDTH  correct next PC, valid while `mispredict` is high
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `underflow`  out  1  sticky: `res_valid` seen while empty

## Operation
- Storage: circular buffer, read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus occupancy counter 0..DEPTH.
- Push: write at wptr, wptr+1, count+1.
- Resolve (`res_valid && count != 0`): pop head (rptr+1, count−1). Next edge: `pc_check` = head pc, `is_br_check` = head is_br, `br_taken_check` = `res_taken & head is_br`.
- Mispredict condition: head is_br and head pred_taken != res_taken. `redirect_pc` = `res_taken ? res_target : head_pc + 4` (modulo 2^PC_WIDTH).
- On mispredict: at the same edge, queue flushed (rptr = wptr = 0, count = 0); a simultaneous push is dropped; `mispredict` pulses high for exactly one cycle after that edge.
- Non-branch entries never mispredict; `is_br_check` stays 0 so predictor state is untouched.
- Simultaneous push and non-mispredicting resolve: both take effect; count unchanged.
- Full: `push_ready` = 0 even if a resolve is presented the same cycle (no pass-through).
- Resolve while empty (including same-cycle push into empty queue): resolve ignored, no check/mispredict pulse, `underflow` set until reset.
- Entries hold no valid bits; contents of unoccupied slots are don't-care.

## Timing
- All outputs registered except `push_ready` and `count`, which derive directly from state registers (no input-to-output combinational path).
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream): count 0, pointers 0, `push_ready` 1, `pc_check` 0, `is_br_check` 0, `br_taken_check` 0, `mispredict` 0, `redirect_pc` 0, `underflow` 0.
- Latency: resolve at edge N → check signals and `mispredict` valid during cycle N→N+1; predictor commits at edge N+1. `is_br_check`/`mispredict` return to 0 at N+1 unless another resolve occurred.
- Back-to-back resolves allowed every cycle; throughput one push and one resolve per cycle.
- `reset_n` low mid-operation: all state and outputs cleared immediately, independent of clk; pending pulses lost.

## Test plan
- Reset: assert `reset_n`=0 mid-stream with count 3 → count 0, `push_ready` 1, all outputs 0 without a clock edge.
- Correct prediction: push pc 0x40 br pred 1, resolve taken 1 target 0x80 → next cycle `pc_check` 0x40, `is_br_check` 1, `br_taken_check` 1, `mispredict` 0, count 0.
- Mispredict not-taken: push 0x10 (br, pred 1), 0x14, 0x18; resolve head taken 0 → `mispredict` 1 for one cycle, `redirect_pc` 0x14, count 0, later resolve sets `underflow`.
- Mispredict taken + dropped push: head 0x20 pred 0, resolve taken 1 target 0x100 with push_valid 1 same cycle → `redirect_pc` 0x100, count 0.
- Full/wrap: push 4 entries → `push_ready` 0; push+resolve same cycle → count 3; continue 10 push/resolve pairs → `pc_check` sequence matches push order across pointer wrap.
- Non-branch: push 0x30 is_br 0 pred 0, resolve taken 1 → `is_br_check` 0, `mispredict` 0, `pc_check` 0x30.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue. Fetch pushes one entry per issued instruction
// along with the prediction it used. Execute resolves the oldest entry with the
// actual outcome. The block drives the predictor's check-side update and raises
// a registered mispredict/redirect. On a mispredict the whole queue is flushed.
//
// Handshake: a push is accepted on a rising edge when push_valid && push_ready.
// push_ready is !full and depends only on state, so a resolve in the same cycle
// cannot free a slot for a push into a full queue. A resolve is taken when
// res_valid is high and the queue is non-empty. It has no ready; a resolve
// against an empty queue is ignored and sets the sticky underflow flag.
module branch_resolve_queue #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [PC_WIDTH-1:0]       push_pc,
  input  logic                      push_is_br,
  input  logic                      push_pred_taken,
  input  logic                      res_valid,
  input  logic                      res_taken,
  input  logic [PC_WIDTH-1:0]       res_target,
  output logic [PC_WIDTH-1:0]       pc_check,
  output logic                      is_br_check,
  output logic                      br_taken_check,
  output logic                      mispredict,
  output logic [PC_WIDTH-1:0]       redirect_pc,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; unoccupied slots are don't-care, so no reset is needed.
  logic [PC_WIDTH-1:0] pc_mem_q [DEPTH];
  logic [DEPTH-1:0]    br_mem_q;
  logic [DEPTH-1:0]    pred_mem_q;

  logic [AW-1:0]       rptr_q, rptr_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic [PC_WIDTH-1:0] pc_check_q, pc_check_d;
  logic                is_br_check_q, is_br_check_d;
  logic                br_taken_check_q, br_taken_check_d;
  logic                mispredict_q, mispredict_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                underflow_q, underflow_d;

  logic                full, empty;
  logic                do_res, do_push, mis;
  logic [PC_WIDTH-1:0] head_pc;
  logic                head_br, head_pred;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full;
  assign count      = count_q;

  assign head_pc    = pc_mem_q[rptr_q];
  assign head_br    = br_mem_q[rptr_q];
  assign head_pred  = pred_mem_q[rptr_q];

  assign do_res     = res_valid && !empty;
  assign mis        = do_res && head_br && (head_pred != res_taken);
  // A push that coincides with a mispredict belongs to the wrong path.
  assign do_push    = push_valid && push_ready && !mis;

  // Next-state for pointers, occupancy and the registered check outputs.
  always_comb begin
    rptr_d           = rptr_q;
    wptr_d           = wptr_q;
    count_d          = count_q;
    pc_check_d       = pc_check_q;
    is_br_check_d    = 1'b0;
    br_taken_check_d = 1'b0;
    mispredict_d     = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    underflow_d      = underflow_q | (res_valid & empty);

    if (mis) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_res)  rptr_d = rptr_q + AW'(1);
      if (do_push) wptr_d = wptr_q + AW'(1);
      case ({do_push, do_res})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (do_res) begin
      pc_check_d       = head_pc;
      is_br_check_d    = head_br;
      br_taken_check_d = res_taken & head_br;
    end

    if (mis) begin
      mispredict_d  = 1'b1;
      redirect_pc_d = res_taken ? res_target : head_pc + PC_WIDTH'(4);
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q           <= '0;
      wptr_q           <= '0;
      count_q          <= '0;
      pc_check_q       <= '0;
      is_br_check_q    <= 1'b0;
      br_taken_check_q <= 1'b0;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      rptr_q           <= rptr_d;
      wptr_q           <= wptr_d;
      count_q          <= count_d;
      pc_check_q       <= pc_check_d;
      is_br_check_q    <= is_br_check_d;
      br_taken_check_q <= br_taken_check_d;
      mispredict_q     <= mispredict_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wptr_q]   <= push_pc;
      br_mem_q[wptr_q]   <= push_is_br;
      pred_mem_q[wptr_q] <= push_pred_taken;
    end
  end

  assign pc_check       = pc_check_q;
  assign is_br_check    = is_br_check_q;
  assign br_taken_check = br_taken_check_q;
  assign mispredict     = mispredict_q;
  assign redirect_pc    = redirect_pc_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue. A queue-based reference model tracks
// the expected outputs. A compare process checks them on every falling edge,
// and literal expectations pin the model at key points.
module tb_branch_resolve_queue;

  localparam int PW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          reset_n;
  logic          push_valid;
  logic          push_ready;
  logic [PW-1:0] push_pc;
  logic          push_is_br;
  logic          push_pred_taken;
  logic          res_valid;
  logic          res_taken;
  logic [PW-1:0] res_target;
  logic [PW-1:0] pc_check;
  logic          is_br_check;
  logic          br_taken_check;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] count;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  branch_resolve_queue #(.PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_pc         (push_pc),
    .push_is_br      (push_is_br),
    .push_pred_taken (push_pred_taken),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .pc_check        (pc_check),
    .is_br_check     (is_br_check),
    .br_taken_check  (br_taken_check),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .count           (count),
    .underflow       (underflow)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  typedef struct {
    logic [PW-1:0] pc;
    logic          br;
    logic          pred;
  } ent_t;

  ent_t          mq[$];
  logic [PW-1:0] m_pc_check  = '0;
  logic          m_is_br     = 1'b0;
  logic          m_bt        = 1'b0;
  logic          m_mis       = 1'b0;
  logic [PW-1:0] m_redirect  = '0;
  logic          m_underflow = 1'b0;
  bit            m_res_ok, m_push_ok, m_flush;
  ent_t          m_head, m_new;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_pc_check  = '0;
      m_is_br     = 1'b0;
      m_bt        = 1'b0;
      m_mis       = 1'b0;
      m_redirect  = '0;
      m_underflow = 1'b0;
    end else begin
      m_res_ok  = res_valid && (mq.size() != 0);
      m_push_ok = push_valid && (mq.size() < DEPTH);
      m_flush   = 0;
      if (res_valid && mq.size() == 0) m_underflow = 1'b1;
      m_is_br = 1'b0;
      m_bt    = 1'b0;
      m_mis   = 1'b0;
      if (m_res_ok) begin
        m_head     = mq.pop_front();
        m_pc_check = m_head.pc;
        m_is_br    = m_head.br;
        m_bt       = m_head.br && res_taken;
        if (m_head.br && (m_head.pred != res_taken)) begin
          m_flush    = 1;
          m_mis      = 1'b1;
          m_redirect = res_taken ? res_target : m_head.pc + 32'd4;
          mq.delete();
        end
      end
      if (m_push_ok && !m_flush) begin
        m_new.pc   = push_pc;
        m_new.br   = push_is_br;
        m_new.pred = push_pred_taken;
        mq.push_back(m_new);
      end
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("count",          PW'(count),          PW'(mq.size()));
      chk("push_ready",     PW'(push_ready),     PW'(mq.size() < DEPTH));
      chk("pc_check",       pc_check,            m_pc_check);
      chk("is_br_check",    PW'(is_br_check),    PW'(m_is_br));
      chk("br_taken_check", PW'(br_taken_check), PW'(m_bt));
      chk("mispredict",     PW'(mispredict),     PW'(m_mis));
      chk("underflow",      PW'(underflow),      PW'(m_underflow));
      if (m_mis) chk("redirect_pc", redirect_pc, m_redirect);
    end
  end

  // Driver: present one cycle of inputs, then return at the next falling edge.
  task automatic step(input logic pv, input logic [PW-1:0] pc, input logic br, input logic pr,
                      input logic rv, input logic rt, input logic [PW-1:0] tg);
    push_valid      = pv;
    push_pc         = pc;
    push_is_br      = br;
    push_pred_taken = pr;
    res_valid       = rv;
    res_taken       = rt;
    res_target      = tg;
    @(posedge clk);
    @(negedge clk);
    push_valid = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    push_pc    = '0;
    res_target = '0;
  endtask

  task automatic push(input logic [PW-1:0] pc, input logic br, input logic pr);
    step(1'b1, pc, br, pr, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic rt, input logic [PW-1:0] tg);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, rt, tg);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    reset_n = 1'b0;
    push_valid = 1'b0; push_pc = '0; push_is_br = 1'b0; push_pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_count",      PW'(count),       32'd0);
    chk("rst_push_ready", PW'(push_ready),  32'd1);
    chk("rst_pc_check",   pc_check,         32'd0);
    chk("rst_mispredict", PW'(mispredict),  32'd0);
    chk("rst_underflow",  PW'(underflow),   32'd0);
    reset_n = 1'b1;
    chk_en  = 1;
    idle();

    // Correct prediction.
    push(32'h40, 1'b1, 1'b1);
    resolve(1'b1, 32'h80);
    chk("ok_pc_check", pc_check,             32'h40);
    chk("ok_is_br",    PW'(is_br_check),     32'd1);
    chk("ok_bt",       PW'(br_taken_check),  32'd1);
    chk("ok_mis",      PW'(mispredict),      32'd0);
    chk("ok_count",    PW'(count),           32'd0);
    idle();
    chk("ok_is_br_off", PW'(is_br_check),    32'd0);

    // Non-branch entry.
    push(32'h30, 1'b0, 1'b0);
    resolve(1'b1, 32'h999);
    chk("nb_pc_check", pc_check,             32'h30);
    chk("nb_is_br",    PW'(is_br_check),     32'd0);
    chk("nb_bt",       PW'(br_taken_check),  32'd0);
    chk("nb_mis",      PW'(mispredict),      32'd0);

    // Mispredict taken with a simultaneous push that must be dropped.
    push(32'h20, 1'b1, 1'b0);
    step(1'b1, 32'h24, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    chk("mt_mis",      PW'(mispredict),      32'd1);
    chk("mt_redirect", redirect_pc,          32'h100);
    chk("mt_count",    PW'(count),           32'd0);
    idle();
    chk("mt_mis_off",  PW'(mispredict),      32'd0);
    chk("mt_count2",   PW'(count),           32'd0);

    // Fill, full push+resolve, then push/resolve pairs across pointer wrap.
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 1'b1, 1'b0);
    chk("full_ready", PW'(push_ready), 32'd0);
    chk("full_count", PW'(count),      32'd4);
    step(1'b1, 32'h210, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("full_pr_count", PW'(count), 32'd3);
    chk("full_pr_pc",    pc_check,   32'h200);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h300 + 32'(4 * i), 1'(i % 2), 1'b0, 1'b1, 1'b0, '0);
      chk("wrap_pc", pc_check, (i < 3) ? 32'h204 + 32'(4 * i) : 32'h300 + 32'(4 * (i - 3)));
      chk("wrap_count", PW'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      resolve(1'b0, '0);
      chk("drain_pc", pc_check, 32'h31c + 32'(4 * i));
    end
    chk("drain_count", PW'(count), 32'd0);

    // Mispredict not-taken, then resolve on the empty queue.
    push(32'h10, 1'b1, 1'b1);
    push(32'h14, 1'b0, 1'b0);
    push(32'h18, 1'b0, 1'b0);
    resolve(1'b0, 32'h500);
    chk("mn_mis",      PW'(mispredict), 32'd1);
    chk("mn_redirect", redirect_pc,     32'h14);
    chk("mn_count",    PW'(count),      32'd0);
    idle();
    chk("mn_mis_off",  PW'(mispredict), 32'd0);
    chk("mn_uf_pre",   PW'(underflow),  32'd0);
    resolve(1'b1, 32'h600);
    chk("uf_set",   PW'(underflow),   32'd1);
    chk("uf_is_br", PW'(is_br_check), 32'd0);
    chk("uf_mis",   PW'(mispredict),  32'd0);
    // Same-cycle push into empty queue with a resolve: resolve ignored.
    step(1'b1, 32'h50, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("pe_count", PW'(count),      32'd1);
    chk("pe_mis",   PW'(mispredict), 32'd0);

    // Mid-stream asynchronous reset with three entries held.
    push(32'h54, 1'b0, 1'b0);
    push(32'h58, 1'b0, 1'b0);
    step(1'b1, 32'h5c, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    chk("pre_rst_count", PW'(count), 32'd3);
    chk("pre_rst_pc",    pc_check,   32'h50);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count",      PW'(count),          32'd0);
    chk("arst_push_ready", PW'(push_ready),     32'd1);
    chk("arst_pc_check",   pc_check,            32'd0);
    chk("arst_is_br",      PW'(is_br_check),    32'd0);
    chk("arst_bt",         PW'(br_taken_check), 32'd0);
    chk("arst_mis",        PW'(mispredict),     32'd0);
    chk("arst_redirect",   redirect_pc,         32'd0);
    chk("arst_underflow",  PW'(underflow),      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(32'h70, 1'b1, 1'b0);
    resolve(1'b0, '0);
    chk("post_rst_pc", pc_check, 32'h70);
    repeat (2) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
